// File: rtl/game_pkg.sv
// Shared types and defaults for the game event generator.
// Holds the FSM state enum, move-count width and default parameters.
package game_pkg;

  localparam int CNT_W         = 4;
  localparam int MAX_MOVES_DEF = 9;
  localparam int TIMEOUT_DEF   = 50_000_000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN_P1,
    S_TURN_P2,
    S_END,
    S_CONFIRMED
  } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// 2-flop synchronizer plus rising-edge detector for one raw button.
// Ports: clk, rst (async active-low), btn (raw), press (1-cycle event).
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic       armed;
  logic [1:0] vld;

  // A button held through reset must be seen low once (after the
  // synchronizer has filled) before any rising edge is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
      vld   <= 2'b00;
    end else begin
      s1    <= btn;
      s2    <= s1;
      prev  <= s2;
      vld   <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & ~s2);
    end
  end

  assign press = armed & s2 & ~prev;

endmodule

// File: rtl/game_event_gen.sv
// Two-player turn/move tracker with turn timeout and end-of-game confirm.
// Ports: clk, rst (async active-low), start, p1_btn, p2_btn in;
//        finalizar, dos_p, turno, move_cnt, timeout_flag out (registered).
module game_event_gen
  import game_pkg::*;
#(
  parameter int MAX_MOVES   = MAX_MOVES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             p1_btn,
  input  logic             p2_btn,
  output logic             finalizar,
  output logic             dos_p,
  output logic             turno,
  output logic [CNT_W-1:0] move_cnt,
  output logic             timeout_flag
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] M_LAST = CNT_W'(MAX_MOVES);

  state_t           state;
  logic [TW-1:0]    timer;
  logic             c1;
  logic             c2;
  logic             p1_press;
  logic             p2_press;
  logic             mv;
  logic [CNT_W-1:0] nxt_cnt;

  btn_sync_edge u_p1 (
    .clk   (clk),
    .rst   (rst),
    .btn   (p1_btn),
    .press (p1_press)
  );

  btn_sync_edge u_p2 (
    .clk   (clk),
    .rst   (rst),
    .btn   (p2_btn),
    .press (p2_press)
  );

  // Only the player on turn can make a move.
  assign mv = ((state == S_TURN_P1) & p1_press) |
              ((state == S_TURN_P2) & p2_press);
  assign nxt_cnt = move_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      c1           <= 1'b0;
      c2           <= 1'b0;
      finalizar    <= 1'b0;
      dos_p        <= 1'b0;
      turno        <= 1'b0;
      move_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      dos_p <= 1'b0;
      unique case (state)
        S_IDLE, S_CONFIRMED: begin
          if (start) begin
            state        <= S_TURN_P1;
            timer        <= '0;
            c1           <= 1'b0;
            c2           <= 1'b0;
            finalizar    <= 1'b0;
            turno        <= 1'b0;
            move_cnt     <= '0;
            timeout_flag <= 1'b0;
          end
        end
        S_TURN_P1, S_TURN_P2: begin
          // A valid press wins over an expiring timer.
          if (mv) begin
            move_cnt <= nxt_cnt;
            timer    <= '0;
            if (nxt_cnt == M_LAST) begin
              state     <= S_END;
              finalizar <= 1'b1;
              turno     <= 1'b0;
            end else if (state == S_TURN_P1) begin
              state <= S_TURN_P2;
              turno <= 1'b1;
            end else begin
              state <= S_TURN_P1;
              turno <= 1'b0;
            end
          end else if (timer == T_LAST) begin
            state        <= S_END;
            finalizar    <= 1'b1;
            turno        <= 1'b0;
            timeout_flag <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_END: begin
          c1 <= c1 | p1_press;
          c2 <= c2 | p2_press;
          if ((c1 | p1_press) & (c2 | p2_press)) begin
            state <= S_CONFIRMED;
            dos_p <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
